// File: rtl/re_mapper_pp.sv
// Resource-element mapper: writes allocated REs of each symbol into one of two grid banks
// while the other bank streams a full NFFT-long grid (zeros outside the allocation).
module re_mapper_pp #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned IQ_W   = 18,
  parameter int unsigned DMRS_W = 9,
  parameter int unsigned NFFT   = 2048,
  parameter int unsigned ADDR_W = 11
) (
  input  logic                     CLK_RE,
  input  logic                     RST_RE,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        N_sc,
  input  logic [6:0]               N_rb,
  input  logic [3:0]               Sym_Start,
  input  logic [3:0]               Sym_End,
  input  logic [3:0]               Dmrs_Sym,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*IQ_W-1:0]   in_I,
  input  logic [NUM_CH*IQ_W-1:0]   in_Q,
  input  logic                     dmrs_valid,
  output logic                     dmrs_ready,
  input  logic [NUM_CH*DMRS_W-1:0] dmrs_I,
  input  logic [NUM_CH*DMRS_W-1:0] dmrs_Q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*IQ_W-1:0]   out_I,
  output logic [NUM_CH*IQ_W-1:0]   out_Q,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [3:0]               out_sym,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);

  localparam int unsigned DW = NUM_CH * IQ_W;
  localparam int unsigned MW = 2 * DW;
  localparam int unsigned CW = ADDR_W + 12;

  typedef enum logic [1:0] {WIdle, WWr, WWait} wr_state_e;
  typedef enum logic {RIdle, RRun} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [ADDR_W-1:0] nsc_q, nsc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   lim_q, lim_d;
  logic [3:0]        sym_end_q, sym_end_d;
  logic [3:0]        dmrs_sym_q, dmrs_sym_d;
  logic [3:0]        wr_sym_q, wr_sym_d;
  logic [ADDR_W:0]   wr_k_q, wr_k_d;
  logic              wr_bank_q, wr_bank_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic [1:0][3:0]   bank_sym_q, bank_sym_d;
  logic              busy_q, busy_d;
  logic              cfg_err_q, cfg_err_d;

  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_issued_q, rd_issued_d;

  logic              s1_v_q, s1_v_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic              s1_rng_q, s1_rng_d;
  logic [3:0]        s1_sym_q, s1_sym_d;
  logic [MW-1:0]     mem_rdata_q;

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [3:0]        out_sym_q, out_sym_d;
  logic              out_last_q, out_last_d;
  logic [DW-1:0]     out_i_q, out_i_d;
  logic [DW-1:0]     out_q_q, out_q_d;

  logic [CW-1:0]     len_full;
  logic              cfg_bad, is_dmrs, can_wr, wr_fire, set_full, start_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [MW-1:0]     wr_data;
  logic [DMRS_W-1:0] dm_i, dm_q;
  logic              issue, stall, out_fire, rd_clear;

  logic [MW-1:0] mem [2*NFFT];

  // Write side: configuration, RE acceptance and write-bank sequencing.
  always_comb begin
    wr_state_d = wr_state_q;
    nsc_d      = nsc_q;
    len_d      = len_q;
    lim_d      = lim_q;
    sym_end_d  = sym_end_q;
    dmrs_sym_d = dmrs_sym_q;
    wr_sym_d   = wr_sym_q;
    wr_k_d     = wr_k_q;
    wr_bank_d  = wr_bank_q;
    bank_sym_d = bank_sym_q;
    cfg_err_d  = 1'b0;
    set_full   = 1'b0;
    start_ok   = 1'b0;
    dm_i       = '0;
    dm_q       = '0;
    wr_data    = '0;

    // 12*N_rb as 8x + 4x; kept wide so an oversized allocation cannot wrap past the check.
    len_full = (CW'(N_rb) << 3) + (CW'(N_rb) << 2);
    cfg_bad  = (N_rb == 7'd0) || ((CW'(N_sc) + len_full) > CW'(NFFT)) || (Sym_End < Sym_Start);

    is_dmrs    = (wr_sym_q == dmrs_sym_q);
    can_wr     = (wr_state_q == WWr) && !bank_full_q[wr_bank_q];
    in_ready   = can_wr && !is_dmrs;
    dmrs_ready = can_wr && is_dmrs;
    wr_fire    = (in_valid && in_ready) || (dmrs_valid && dmrs_ready);
    wr_addr    = nsc_q + wr_k_q[ADDR_W-1:0];

    for (int c = 0; c < NUM_CH; c++) begin
      dm_i = dmrs_I[c*DMRS_W +: DMRS_W];
      dm_q = dmrs_Q[c*DMRS_W +: DMRS_W];
      wr_data[c*IQ_W +: IQ_W] = is_dmrs ? {{(IQ_W-DMRS_W){dm_i[DMRS_W-1]}}, dm_i}
                                        : in_I[c*IQ_W +: IQ_W];
      wr_data[DW + c*IQ_W +: IQ_W] = is_dmrs ? {{(IQ_W-DMRS_W){dm_q[DMRS_W-1]}}, dm_q}
                                             : in_Q[c*IQ_W +: IQ_W];
    end

    unique case (wr_state_q)
      WIdle: begin
        if (start && !busy_q) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            start_ok   = 1'b1;
            nsc_d      = N_sc;
            len_d      = len_full[ADDR_W:0];
            lim_d      = {1'b0, N_sc} + len_full[ADDR_W:0];
            sym_end_d  = Sym_End;
            dmrs_sym_d = Dmrs_Sym;
            wr_sym_d   = Sym_Start;
            wr_k_d     = '0;
            wr_state_d = WWr;
          end
        end
      end
      WWr: begin
        if (wr_fire) begin
          if (wr_k_q == len_q - 1'b1) begin
            set_full              = 1'b1;
            bank_sym_d[wr_bank_q] = wr_sym_q;
            wr_bank_d             = ~wr_bank_q;
            wr_k_d                = '0;
            if (wr_sym_q == sym_end_q) begin
              wr_state_d = WIdle;
            end else begin
              wr_sym_d   = wr_sym_q + 4'd1;
              wr_state_d = bank_full_q[~wr_bank_q] ? WWait : WWr;
            end
          end else begin
            wr_k_d = wr_k_q + 1'b1;
          end
        end
      end
      WWait: begin
        if (!bank_full_q[wr_bank_q]) wr_state_d = WWr;
      end
      default: wr_state_d = WIdle;
    endcase
  end

  // Read side: address issue, memory stage and registered output stage share one stall.
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_bank_d   = rd_bank_q;
    rd_addr_d   = rd_addr_q;
    rd_issued_d = rd_issued_q;
    issue       = 1'b0;
    rd_clear    = 1'b0;
    s1_v_d      = s1_v_q;
    s1_addr_d   = s1_addr_q;
    s1_rng_d    = s1_rng_q;
    s1_sym_d    = s1_sym_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_sym_d   = out_sym_q;
    out_last_d  = out_last_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;

    stall    = out_valid_q && !out_ready;
    out_fire = out_valid_q && out_ready;

    unique case (rd_state_q)
      RIdle: begin
        if (bank_full_q[rd_bank_q] && !stall) begin
          issue      = 1'b1;
          rd_state_d = RRun;
        end
      end
      RRun: begin
        if (!stall && !rd_issued_q) issue = 1'b1;
      end
      default: rd_state_d = RIdle;
    endcase

    if (issue) begin
      if (rd_addr_q == ADDR_W'(NFFT - 1)) begin
        rd_addr_d   = '0;
        rd_issued_d = 1'b1;
      end else begin
        rd_addr_d = rd_addr_q + 1'b1;
      end
    end

    if (rd_state_q == RRun && out_fire && out_last_q) begin
      rd_clear    = 1'b1;
      rd_bank_d   = ~rd_bank_q;
      rd_issued_d = 1'b0;
      rd_state_d  = RIdle;
    end

    if (!stall) begin
      s1_v_d      = issue;
      s1_addr_d   = rd_addr_q;
      s1_rng_d    = (rd_addr_q >= nsc_q) && ({1'b0, rd_addr_q} < lim_q);
      s1_sym_d    = bank_sym_q[rd_bank_q];
      out_valid_d = s1_v_q;
      out_addr_d  = s1_addr_q;
      out_sym_d   = s1_sym_q;
      out_last_d  = s1_v_q && (s1_addr_q == ADDR_W'(NFFT - 1));
      out_i_d     = s1_rng_q ? mem_rdata_q[DW-1:0] : '0;
      out_q_d     = s1_rng_q ? mem_rdata_q[MW-1:DW] : '0;
    end

    done = rd_clear && busy_q && (out_sym_q == sym_end_q);
  end

  // Bank ownership and status; set and clear target different banks so both apply.
  always_comb begin
    bank_full_d = bank_full_q;
    if (set_full) bank_full_d[wr_bank_q] = 1'b1;
    if (rd_clear) bank_full_d[rd_bank_q] = 1'b0;
    busy_d = busy_q;
    if (start_ok) busy_d = 1'b1;
    if (done)     busy_d = 1'b0;
  end

  always_ff @(posedge CLK_RE or negedge RST_RE) begin
    if (!RST_RE) begin
      wr_state_q  <= WIdle;
      rd_state_q  <= RIdle;
      nsc_q       <= '0;
      len_q       <= '0;
      lim_q       <= '0;
      sym_end_q   <= '0;
      dmrs_sym_q  <= '0;
      wr_sym_q    <= '0;
      wr_k_q      <= '0;
      wr_bank_q   <= 1'b0;
      bank_full_q <= '0;
      bank_sym_q  <= '0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      rd_issued_q <= 1'b0;
      s1_v_q      <= 1'b0;
      s1_addr_q   <= '0;
      s1_rng_q    <= 1'b0;
      s1_sym_q    <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_sym_q   <= '0;
      out_last_q  <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
    end else begin
      wr_state_q  <= wr_state_d;
      rd_state_q  <= rd_state_d;
      nsc_q       <= nsc_d;
      len_q       <= len_d;
      lim_q       <= lim_d;
      sym_end_q   <= sym_end_d;
      dmrs_sym_q  <= dmrs_sym_d;
      wr_sym_q    <= wr_sym_d;
      wr_k_q      <= wr_k_d;
      wr_bank_q   <= wr_bank_d;
      bank_full_q <= bank_full_d;
      bank_sym_q  <= bank_sym_d;
      busy_q      <= busy_d;
      cfg_err_q   <= cfg_err_d;
      rd_bank_q   <= rd_bank_d;
      rd_addr_q   <= rd_addr_d;
      rd_issued_q <= rd_issued_d;
      s1_v_q      <= s1_v_d;
      s1_addr_q   <= s1_addr_d;
      s1_rng_q    <= s1_rng_d;
      s1_sym_q    <= s1_sym_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_sym_q   <= out_sym_d;
      out_last_q  <= out_last_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
    end
  end

  // Grid storage is never cleared; out-of-allocation indices are zeroed on the read path.
  always_ff @(posedge CLK_RE) begin
    if (wr_fire) mem[{wr_bank_q, wr_addr}] <= wr_data;
    if (issue)   mem_rdata_q <= mem[{rd_bank_q, rd_addr_q}];
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_sym   = out_sym_q;
  assign out_last  = out_last_q;
  assign out_I     = out_i_q;
  assign out_Q     = out_q_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_re_mapper_pp.sv
// Directed jobs with random RE data and handshakes, checked against a grid model
// built from the allocation rules (zeros outside [N_sc, N_sc+12*N_rb)).
module tb_re_mapper_pp;
  localparam int NUM_CH = 2;
  localparam int IQ_W   = 18;
  localparam int DMRS_W = 9;
  localparam int NFFT   = 64;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [ADDR_W-1:0] N_sc;
  logic [6:0] N_rb;
  logic [3:0] Sym_Start, Sym_End, Dmrs_Sym;
  logic in_valid, in_ready, dmrs_valid, dmrs_ready, out_valid, out_ready;
  logic [NUM_CH*IQ_W-1:0] in_I, in_Q, out_I, out_Q;
  logic [NUM_CH*DMRS_W-1:0] dmrs_I, dmrs_Q;
  logic [ADDR_W-1:0] out_addr;
  logic [3:0] out_sym;
  logic out_last, busy, done, cfg_err;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  logic [17:0] g_i [16][64][2];
  logic [17:0] g_q [16][64][2];
  int accepted, bad_ready, lat_acc_cyc, first_valid_cyc, p_timeout, dones;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  re_mapper_pp #(
    .NUM_CH(NUM_CH), .IQ_W(IQ_W), .DMRS_W(DMRS_W), .NFFT(NFFT), .ADDR_W(ADDR_W)
  ) dut (
    .CLK_RE(clk), .RST_RE(rst_n), .start(start), .N_sc(N_sc), .N_rb(N_rb),
    .Sym_Start(Sym_Start), .Sym_End(Sym_End), .Dmrs_Sym(Dmrs_Sym),
    .in_valid(in_valid), .in_ready(in_ready), .in_I(in_I), .in_Q(in_Q),
    .dmrs_valid(dmrs_valid), .dmrs_ready(dmrs_ready), .dmrs_I(dmrs_I), .dmrs_Q(dmrs_Q),
    .out_valid(out_valid), .out_ready(out_ready), .out_I(out_I), .out_Q(out_Q),
    .out_addr(out_addr), .out_sym(out_sym), .out_last(out_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] status_vec();
    return 128'({in_ready, dmrs_ready, out_valid, out_last, busy, done, cfg_err,
                 out_I, out_Q, out_addr, out_sym});
  endfunction

  // mode 0: FFT RE k carries value k, DMRS carries I=-3/Q=+2; mode 1: random values.
  task automatic build(input int nsc, input int nrb, input int s0, input int s1,
                       input int dm, input int mode);
    logic signed [8:0] r9;
    int v;
    for (int s = s0; s <= s1; s++) begin
      for (int a = 0; a < NFFT; a++)
        for (int c = 0; c < NUM_CH; c++) begin
          g_i[s][a][c] = '0;
          g_q[s][a][c] = '0;
        end
      for (int k = 0; k < 12 * nrb; k++)
        for (int c = 0; c < NUM_CH; c++) begin
          if (s == dm && mode == 0) begin
            v = -3; g_i[s][nsc+k][c] = 18'(v);
            v = 2;  g_q[s][nsc+k][c] = 18'(v);
          end else if (s == dm) begin
            r9 = 9'($urandom); v = r9; g_i[s][nsc+k][c] = 18'(v);
            r9 = 9'($urandom); v = r9; g_q[s][nsc+k][c] = 18'(v);
          end else if (mode == 0) begin
            g_i[s][nsc+k][c] = 18'(k);
            g_q[s][nsc+k][c] = 18'(k);
          end else begin
            g_i[s][nsc+k][c] = 18'($urandom);
            g_q[s][nsc+k][c] = 18'($urandom);
          end
        end
    end
  endtask

  task automatic produce(input int nsc, input int nrb, input int s0, input int s1, input int dm);
    int pcyc = 0;
    bit acc, vld, is_dm;
    for (int s = s0; s <= s1; s++) begin
      is_dm = (s == dm);
      for (int k = 0; k < 12 * nrb; k++) begin
        acc = 1'b0;
        while (!acc && pcyc < 4000) begin
          @(negedge clk);
          pcyc++;
          vld = ($urandom_range(3) != 0);
          for (int c = 0; c < NUM_CH; c++) begin
            in_I[c*IQ_W +: IQ_W] = is_dm ? 18'($urandom) : g_i[s][nsc+k][c];
            in_Q[c*IQ_W +: IQ_W] = is_dm ? 18'($urandom) : g_q[s][nsc+k][c];
            dmrs_I[c*DMRS_W +: DMRS_W] = is_dm ? g_i[s][nsc+k][c][8:0] : 9'($urandom);
            dmrs_Q[c*DMRS_W +: DMRS_W] = is_dm ? g_q[s][nsc+k][c][8:0] : 9'($urandom);
          end
          // The port not in use for this symbol is driven valid with junk.
          in_valid   = is_dm ? 1'b1 : vld;
          dmrs_valid = is_dm ? vld : 1'b1;
          #1;
          if (is_dm ? in_ready : dmrs_ready) bad_ready++;
          if (vld && (is_dm ? dmrs_ready : in_ready)) begin
            acc = 1'b1;
            accepted++;
            if (s == s0 && k == 12 * nrb - 1) lat_acc_cyc = cyc;
          end
        end
        if (!acc) p_timeout = 1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    dmrs_valid = 1'b0;
  endtask

  task automatic consume(input int s0, input int s1, input int hold, input bit rnd,
                         input int len);
    int nexp = (s1 - s0 + 1) * NFFT;
    int got = 0;
    int ccyc = 0;
    int sym, a;
    bit prev_stall = 1'b0;
    logic [127:0] cur, saved;
    saved = '0;
    while (got < nexp && ccyc < 4000) begin
      @(negedge clk);
      ccyc++;
      out_ready = (ccyc <= hold) ? 1'b0 : (rnd ? 1'($urandom) : 1'b1);
      if (hold != 0 && ccyc == 10) begin
        N_sc = 6'd0; N_rb = 7'd1; Sym_Start = 4'd7; Sym_End = 4'd7; start = 1'b1;
      end
      if (ccyc == 11) start = 1'b0;
      #1;
      cur = 128'({out_valid, out_addr, out_sym, out_last, out_I, out_Q});
      if (prev_stall) check("hold_stable", cur, saved);
      if (hold != 0 && ccyc == hold) begin
        check("stall_accepted", 128'(accepted), 128'(2 * len));
        check("stall_in_ready", 128'(in_ready), 128'(0));
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) dones++;
      if (out_valid && out_ready) begin
        sym = s0 + got / NFFT;
        a   = got % NFFT;
        check("out_entry", 128'({out_addr, out_sym, out_last, out_I, out_Q}),
              128'({6'(a), 4'(sym), a == NFFT - 1, g_i[sym][a][1], g_i[sym][a][0],
                    g_q[sym][a][1], g_q[sym][a][0]}));
        check("done_at_entry", 128'(done), 128'(a == NFFT - 1 && sym == s1));
        got++;
      end
      prev_stall = out_valid && !out_ready;
      saved = cur;
    end
    out_ready = 1'b1;
    check("all_outputs", 128'(got), 128'(nexp));
  endtask

  task automatic run_job(input int nsc, input int nrb, input int s0, input int s1,
                         input int dm, input int mode, input int hold, input bit rnd,
                         input bit lat);
    int extra = 0;
    build(nsc, nrb, s0, s1, dm, mode);
    accepted = 0; bad_ready = 0; p_timeout = 0; dones = 0;
    first_valid_cyc = -1; lat_acc_cyc = 0;
    @(negedge clk);
    N_sc = 6'(nsc); N_rb = 7'(nrb); Sym_Start = 4'(s0); Sym_End = 4'(s1); Dmrs_Sym = 4'(dm);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_after_start", 128'(busy), 128'(1));
    fork
      produce(nsc, nrb, s0, s1, dm);
      consume(s0, s1, hold, rnd, 12 * nrb);
    join
    repeat (5) begin
      @(negedge clk);
      #1;
      if (out_valid) extra++;
    end
    check("no_extra_output", 128'(extra), 128'(0));
    check("busy_cleared", 128'(busy), 128'(0));
    check("done_once", 128'(dones), 128'(1));
    check("wrong_port_ready", 128'(bad_ready), 128'(0));
    check("producer_timeout", 128'(p_timeout), 128'(0));
    if (lat) check("first_valid_latency", 128'(first_valid_cyc - lat_acc_cyc <= 3), 128'(1));
  endtask

  task automatic cfg_check(input int nsc, input int nrb, input int s0, input int s1,
                           input string tag);
    int act = 0;
    @(negedge clk);
    N_sc = 6'(nsc); N_rb = 7'(nrb); Sym_Start = 4'(s0); Sym_End = 4'(s1); Dmrs_Sym = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, "_err"}, 128'({cfg_err, busy}), 128'(2'b10));
    @(negedge clk);
    #1;
    check({tag, "_pulse"}, 128'(cfg_err), 128'(0));
    repeat (5) begin
      @(negedge clk);
      #1;
      if (out_valid || in_ready || dmrs_ready || busy) act++;
    end
    check({tag, "_idle"}, 128'(act), 128'(0));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; N_sc = '0; N_rb = '0;
    Sym_Start = '0; Sym_End = '0; Dmrs_Sym = '0;
    in_valid = 1'b0; dmrs_valid = 1'b0; out_ready = 1'b1;
    in_I = '0; in_Q = '0; dmrs_I = '0; dmrs_Q = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", status_vec(), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    cfg_check(60, 1, 0, 0, "cfg_overflow");
    cfg_check(0, 0, 0, 0, "cfg_zero_rb");
    cfg_check(0, 1, 3, 2, "cfg_sym_order");

    run_job(10, 1, 0, 0, 5, 0, 0, 1'b0, 1'b1);
    run_job(3, 2, 0, 2, 1, 0, 0, 1'b0, 1'b0);
    run_job(20, 2, 0, 3, 9, 1, 300, 1'b1, 1'b0);

    // Abandon a job part-way through a symbol.
    @(negedge clk);
    N_sc = 6'd5; N_rb = 7'd2; Sym_Start = 4'd0; Sym_End = 4'd1; Dmrs_Sym = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_I = 36'($urandom);
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_symbol", status_vec(), 128'(0));
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_job(52, 1, 2, 4, 3, 1, 0, 1'b1, 1'b0);
    run_job(0, 5, 5, 6, 6, 1, 0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/re_mapper_pp.md
RE_MAPPER_PP -- requirements
Module: re_mapper_pp

Interface
REQ-001 SHALL have parameters: NUM_CH, default 2, number of antenna/layer channels; IQ_W, default 18, sample width per component; DMRS_W, default 9, DMRS width per component; NFFT, default 2048, grid length per symbol; ADDR_W, default 11, log2(NFFT).
REQ-002 SHALL have ports:
CLK_RE  in  1  sole clock, rising edge.
RST_RE  in  1  asynchronous active-low reset.
start  in  1  pulse; loads configuration.
N_sc  in  ADDR_W  first allocated subcarrier.
N_rb  in  7  allocated RBs.
Sym_Start / Sym_End / Dmrs_Sym  in  4 each  first, last and DMRS symbol index.
in_valid / in_ready  in / out  1  FFT data handshake.
in_I / in_Q  in  NUM_CH*IQ_W  signed FFT samples; channel c occupies bits [c*IQ_W +: IQ_W].
dmrs_valid / dmrs_ready  in / out  1  DMRS handshake.
dmrs_I / dmrs_Q  in  NUM_CH*DMRS_W  signed DMRS samples.
out_valid / out_ready  out / in  1  grid output handshake.
out_I / out_Q  out  NUM_CH*IQ_W  mapped samples.
out_addr  out  ADDR_W  grid index; out_sym  out  4  symbol index; out_last  out  1  marks grid index NFFT-1.
busy, done, cfg_err  out  1 each  status.

Function
REQ-003 SHALL latch configuration on start while busy=0; SHALL ignore start while busy=1.
REQ-004 SHALL compute LEN = 12*N_rb at ADDR_W+1 bits, using shift-add only.
REQ-005 SHALL pulse cfg_err for 1 cycle and remain idle if N_rb=0, N_sc+LEN>NFFT, or Sym_End<Sym_Start.
REQ-006 Write FSM: IDLE -> WR on valid start; WR -> WAIT when a symbol completes and the other bank is full; WAIT -> WR when that bank frees; WR -> IDLE after symbol Sym_End completes.
REQ-007 In WR for symbol s: if s==Dmrs_Sym, SHALL accept from the DMRS port only (in_ready=0); otherwise from the FFT port only (dmrs_ready=0). Ready SHALL be 0 in IDLE and WAIT.
REQ-008 SHALL write the k-th accepted RE (k=0..LEN-1) of all NUM_CH channels into the current bank at address N_sc+k in the same cycle. DMRS values SHALL be sign-extended to IQ_W.
REQ-009 On acceptance of RE LEN-1, SHALL set bank_full for the current bank and toggle the write bank.
REQ-010 Read FSM: R_IDLE -> R_RUN when the read bank is full; SHALL stream grid indices 0..NFFT-1 in order; on out_last handshake SHALL clear that bank's bank_full, toggle the read bank, and return to R_IDLE.
REQ-011 Grid indices outside [N_sc, N_sc+LEN) SHALL output 0 on all channels. Memories are never cleared.
REQ-012 Synchronous-read memory SHALL feed a registered output stage. out_* SHALL hold stable while out_valid=1 and out_ready=0. First out_valid SHALL occur within 3 cycles of bank_full being set. Sustained throughput SHALL be 1 entry/cycle with out_ready=1.
REQ-013 Simultaneous set (write side) and clear (read side) of bank_full on different banks SHALL both take effect.
REQ-014 out_sym SHALL equal the symbol index written into the bank being read.
REQ-015 done SHALL pulse 1 cycle on the out_last handshake of symbol Sym_End. busy SHALL be 1 from the accepted start through that cycle.

Reset
REQ-016 With RST_RE=0, all FSMs SHALL be idle, bank_full=0 and bank pointers=0. in_ready, dmrs_ready, out_valid, out_last, busy, done and cfg_err SHALL be 0; out_I, out_Q, out_addr and out_sym SHALL be 0. Reset mid-operation SHALL abandon all data.

Verification (NFFT=64, ADDR_W=6, NUM_CH=2)
REQ-017 Reset asserted mid-symbol -> all outputs 0 next edge; a subsequent start runs cleanly.
REQ-018 N_sc=10, N_rb=1, Sym 0..0, Dmrs_Sym=5, FFT values k=0..11 -> 64 outputs; addr 10..21 carry k on both channels, all others 0; out_last at addr 63; done pulses once.
REQ-019 Sym 0..2, Dmrs_Sym=1, DMRS I=-3, Q=+2 -> in_ready=0 throughout symbol 1; symbol-1 outputs read -3/+2 sign-extended to 18 bits.
REQ-020 Sym 0..3 with out_ready=0 for 300 cycles -> in_ready drops after two symbols are written; after release, symbols 0..3 appear in order with no loss or duplication.
REQ-021 N_sc=60, N_rb=1 -> cfg_err pulses 1 cycle; busy stays 0; no output.
REQ-022 Random out_ready toggling -> out_* stable whenever out_valid=1 and out_ready=0.
